// File: rtl/tick_gen_multi.sv
// Multi-channel tick generator: one-cycle enable pulse every P cycles
// plus a 50% square wave per channel, with run-time loadable periods.
module tick_gen_multi #(
  parameter int NUM_CH = 3,
  parameter int CNT_W = 27,
  parameter logic [NUM_CH*CNT_W-1:0] DEF_PERIODS =
    {27'd150000, 27'd500000, 27'd100000000}
) (
  input  logic                    Clk100M,
  input  logic                    ResetN,
  input  logic [NUM_CH-1:0]       En,
  input  logic [NUM_CH-1:0]       Restart,
  input  logic [NUM_CH-1:0]       LoadPeriod,
  input  logic [CNT_W-1:0]        PeriodIn,
  output logic [NUM_CH-1:0]       Tick,
  output logic [NUM_CH-1:0]       Sq,
  output logic [NUM_CH*CNT_W-1:0] PeriodOut
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] period;
    logic             last;

    // cnt never exceeds period-1, so equality is the only wrap test needed
    assign last = (cnt == period - CNT_W'(1));

    always_ff @(posedge Clk100M) begin
      if (!ResetN) begin
        cnt     <= '0;
        period  <= DEF_PERIODS[i*CNT_W +: CNT_W];
        Tick[i] <= 1'b0;
        Sq[i]   <= 1'b0;
      end else if (LoadPeriod[i]) begin
        period  <= PeriodIn;
        cnt     <= '0;
        Tick[i] <= 1'b0;
      end else if (Restart[i]) begin
        cnt     <= '0;
        Tick[i] <= 1'b0;
      end else if (!En[i]) begin
        Tick[i] <= 1'b0;
      end else if (period == '0) begin
        cnt     <= '0;
        Tick[i] <= 1'b0;
      end else if (last) begin
        cnt     <= '0;
        Tick[i] <= 1'b1;
        Sq[i]   <= ~Sq[i];
      end else begin
        cnt     <= cnt + CNT_W'(1);
        Tick[i] <= 1'b0;
      end
    end

    assign PeriodOut[i*CNT_W +: CNT_W] = period;
  end

endmodule

// File: tb/tb_tick_gen_multi.sv
// Scoreboard bench for tick_gen_multi: driver pushes model predictions,
// monitor pops and compares on the falling edge.
module tb_tick_gen_multi;

  localparam int NCH = 3;
  localparam int CW = 8;
  localparam logic [NCH*CW-1:0] DEF = {8'd7, 8'd5, 8'd3};

  typedef struct {
    logic [NCH-1:0]    tick;
    logic [NCH-1:0]    sq;
    logic [NCH*CW-1:0] per;
  } exp_t;

  logic              clk;
  logic              rstn;
  logic [NCH-1:0]    en;
  logic [NCH-1:0]    restart;
  logic [NCH-1:0]    load;
  logic [CW-1:0]     pin;
  logic [NCH-1:0]    tick;
  logic [NCH-1:0]    sq;
  logic [NCH*CW-1:0] pout;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  int   def_p[NCH] = '{3, 5, 7};
  int   m_p[NCH];
  int   m_e[NCH];
  bit   m_sq[NCH];

  tick_gen_multi #(
    .NUM_CH(NCH),
    .CNT_W(CW),
    .DEF_PERIODS(DEF)
  ) dut (
    .Clk100M(clk),
    .ResetN(rstn),
    .En(en),
    .Restart(restart),
    .LoadPeriod(load),
    .PeriodIn(pin),
    .Tick(tick),
    .Sq(sq),
    .PeriodOut(pout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h required %h", nm, $time, act, req);
    end
  endtask

  // Model counts enabled edges since the last clear; a tick falls
  // on every multiple of the period.
  task automatic step(input logic r, input logic [NCH-1:0] e,
                      input logic [NCH-1:0] rs, input logic [NCH-1:0] ld,
                      input logic [CW-1:0] pi);
    exp_t x;
    rstn = r; en = e; restart = rs; load = ld; pin = pi;
    x.tick = '0;
    for (int i = 0; i < NCH; i++) begin
      if (!r) begin
        m_p[i] = def_p[i]; m_e[i] = 0; m_sq[i] = 1'b0;
      end else if (ld[i]) begin
        m_p[i] = int'(pi); m_e[i] = 0;
      end else if (rs[i]) begin
        m_e[i] = 0;
      end else if (!e[i]) begin
      end else if (m_p[i] == 0) begin
        m_e[i] = 0;
      end else begin
        m_e[i]++;
        if (m_e[i] % m_p[i] == 0) begin
          x.tick[i] = 1'b1;
          m_sq[i] = ~m_sq[i];
        end
      end
      x.sq[i] = m_sq[i];
      x.per[i*CW +: CW] = CW'(m_p[i]);
    end
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic [NCH-1:0] e);
    for (int k = 0; k < n; k++) step(1'b1, e, '0, '0, '0);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("tick", 32'(tick), 32'(x.tick));
      chk("sq", 32'(sq), 32'(x.sq));
      chk("period", 32'(pout), 32'(x.per));
    end
  end

  initial begin
    logic [NCH-1:0] re, rr, rl;
    logic [CW-1:0]  rp;
    rstn = 1'b0; en = '0; restart = '0; load = '0; pin = '0;

    // reset then defaults run
    step(1'b0, '0, '0, '0, '0);
    step(1'b0, '0, '0, '0, '0);
    run(16, 3'b111);

    // ch0 period 4
    step(1'b1, 3'b111, 3'b000, 3'b001, 8'd4);
    run(13, 3'b111);

    // ch1 period 5 with a 3-cycle hold after 2 counts
    step(1'b1, 3'b000, 3'b000, 3'b010, 8'd5);
    run(2, 3'b010);
    run(3, 3'b000);
    run(8, 3'b010);

    // ch2 period 6, restart at count 4, then restart+load together
    step(1'b1, 3'b000, 3'b000, 3'b100, 8'd6);
    run(4, 3'b100);
    step(1'b1, 3'b100, 3'b100, 3'b000, 8'd0);
    run(8, 3'b100);
    step(1'b1, 3'b100, 3'b100, 3'b100, 8'd3);
    run(7, 3'b100);

    // P=1, then P=0, then the largest period on ch1
    step(1'b1, 3'b111, 3'b000, 3'b001, 8'd1);
    run(6, 3'b111);
    step(1'b1, 3'b111, 3'b000, 3'b001, 8'd0);
    run(6, 3'b111);
    step(1'b1, 3'b111, 3'b000, 3'b010, 8'd255);
    run(520, 3'b111);

    // reset overrides everything mid-period
    run(2, 3'b111);
    step(1'b0, 3'b111, 3'b111, 3'b111, 8'd9);
    run(10, 3'b111);

    // random phase
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < NCH; i++) begin
        re[i] = ($urandom_range(0, 99) < 80);
        rr[i] = ($urandom_range(0, 99) < 3);
        rl[i] = ($urandom_range(0, 99) < 3);
      end
      rp = ($urandom_range(0, 19) == 0) ? 8'd255 : CW'($urandom_range(0, 9));
      step(($urandom_range(0, 199) != 0), re, rr, rl, rp);
    end

    repeat (2) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending required 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
